// File: rtl/sr_pulse_gen.sv
// Command stage for the negedge set/reset flip-flop: sync, debounce, edge-latch, arbitrate.
// Optional SR_CONFLICT_EN: simultaneous set+clr requests cancel each other and raise conflict.
module sr_pulse_gen #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned HOLDOFF   = 2
) (
    input  logic ck,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    // Channel index 0 = set, 1 = clr.
    logic [1:0] raw;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] filt_q, filt_d, filt_prev_q;
    logic [1:0] pend_q, pend_d;
    logic [1:0] rise, take;
    logic [7:0] db_cnt_q [2];
    logic [7:0] db_cnt_d [2];

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       ready;

    assign raw = {clr_in, set_in};

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            filt_d[i]   = filt_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == 8'(DB_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign rise = filt_q & ~filt_prev_q;

    // The last hold cycle doubles as an idle decision slot, so the next
    // pulse can follow exactly HOLDOFF empty cycles after the previous one.
    assign ready = (state_q == IDLE) || (hold_q == '0);

`ifdef SR_CONFLICT_EN
    logic conflict_q, conflict_d;
`endif

    always_comb begin
        take    = '0;
        s_d     = 1'b0;
        r_d     = 1'b0;
        state_d = state_q;
        hold_d  = hold_q;
`ifdef SR_CONFLICT_EN
        conflict_d = 1'b0;
`endif
        if (state_q == HOLD) begin
            if (hold_q != '0) begin
                hold_d = hold_q - 8'd1;
            end else begin
                state_d = IDLE;
            end
        end
        if (ready) begin
`ifdef SR_CONFLICT_EN
            if (pend_q == 2'b11) begin
                take       = 2'b11;
                conflict_d = 1'b1;
                state_d    = HOLD;
                hold_d     = 8'(HOLDOFF);
            end else
`endif
            if (pend_q[0]) begin
                take    = 2'b01;
                s_d     = 1'b1;
                state_d = HOLD;
                hold_d  = 8'(HOLDOFF);
            end else if (pend_q[1]) begin
                take    = 2'b10;
                r_d     = 1'b1;
                state_d = HOLD;
                hold_d  = 8'(HOLDOFF);
            end
        end
    end

    assign pend_d = (pend_q & ~take) | rise;

    always_ff @(posedge ck) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            pend_q      <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q <= IDLE;
            hold_q  <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
`ifdef SR_CONFLICT_EN
            conflict_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            pend_q      <= pend_d;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q <= state_d;
            hold_q  <= hold_d;
            s_q     <= s_d;
            r_q     <= r_d;
`ifdef SR_CONFLICT_EN
            conflict_q <= conflict_d;
`endif
        end
    end

    assign s    = s_q;
    assign r    = r_q;
    assign busy = (state_q != IDLE) || (pend_q != '0);

`ifdef SR_CONFLICT_EN
    assign conflict = conflict_q;
`else
    assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Scoreboard bench for sr_pulse_gen (DB_CYCLES=4, HOLDOFF=2); edges are counted from each reset edge.
module tb_sr_pulse_gen;

    logic ck = 1'b0;
    logic rst = 1'b1;
    logic set_in = 1'b0;
    logic clr_in = 1'b0;
    logic s, r, busy, conflict;

    localparam logic [2:0] K_S = 3'b001;
    localparam logic [2:0] K_R = 3'b010;
    localparam logic [2:0] K_C = 3'b100;

    sr_pulse_gen #(.DB_CYCLES(4), .HOLDOFF(2)) dut (
        .ck(ck),
        .rst(rst),
        .set_in(set_in),
        .clr_in(clr_in),
        .s(s),
        .r(r),
        .busy(busy),
        .conflict(conflict)
    );

    always #5 ck = ~ck;

    typedef struct {
        int         e;
        logic [2:0] kind;
    } ev_t;

    ev_t evq[$];
    ev_t bq[$];
    int  total = 0;
    int  bad = 0;
    int  edge_no = 0;
    int  base = 0;

    always @(posedge ck) edge_no <= edge_no + 1;

    always @(negedge ck) begin : monitor
        logic [2:0] k;
        ev_t        e;
        k = {conflict, r, s};
        if (k != 3'b000) begin
            total++;
            if (evq.size() == 0) begin
                bad++;
                $display("FAIL pulse: got {c,r,s}=%b at edge +%0d, required none", k, edge_no - base);
            end else begin
                e = evq.pop_front();
                if (e.e != edge_no || e.kind != k) begin
                    bad++;
                    $display("FAIL pulse: got {c,r,s}=%b at edge +%0d, required %b at edge +%0d",
                             k, edge_no - base, e.kind, e.e - base);
                end
            end
        end
        while (evq.size() > 0 && evq[0].e < edge_no) begin
            e = evq.pop_front();
            total++;
            bad++;
            $display("FAIL pulse_missing: got none, required %b at edge +%0d", e.kind, e.e - base);
        end
        while (bq.size() > 0 && bq[0].e < edge_no) begin
            e = bq.pop_front();
            total++;
            bad++;
            $display("FAIL busy_missed: check for edge +%0d not reached", e.e - base);
        end
        if (bq.size() > 0 && bq[0].e == edge_no) begin
            e = bq.pop_front();
            total++;
            if (busy !== e.kind[0]) begin
                bad++;
                $display("FAIL busy: got %b at edge +%0d, required %b", busy, edge_no - base, e.kind[0]);
            end
        end
    end

    task automatic exp_pulse(input int rel, input logic [2:0] kind);
        ev_t e;
        e.e = base + rel;
        e.kind = kind;
        evq.push_back(e);
    endtask

    task automatic exp_busy(input int rel, input logic v);
        ev_t e;
        e.e = base + rel;
        e.kind = {2'b00, v};
        bq.push_back(e);
    endtask

    // Returns at the negedge just before edge base+k, so inputs driven now are sampled at it.
    task automatic at_edge(input int k);
        while (edge_no < base + k - 1) @(negedge ck);
    endtask

    task automatic do_reset();
        @(negedge ck);
        rst = 1'b1;
        set_in = 1'b0;
        clr_in = 1'b0;
        @(negedge ck);
        base = edge_no;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge ck);

        // 1: single set request, latency and hold-off window
        do_reset();
        exp_busy(1, 1'b0);
        exp_busy(15, 1'b0);
        exp_busy(16, 1'b1);
        exp_busy(17, 1'b1);
        exp_busy(19, 1'b1);
        exp_busy(20, 1'b0);
        exp_busy(35, 1'b0);
        exp_pulse(17, K_S);
        at_edge(10); set_in = 1'b1;
        at_edge(25); set_in = 1'b0;
        at_edge(40);

        // 2: bounces shorter than the debounce window never produce a request
        do_reset();
        exp_busy(1, 1'b0);
        exp_busy(15, 1'b0);
        exp_busy(25, 1'b0);
        exp_busy(33, 1'b0);
        exp_busy(44, 1'b0);
        at_edge(10); set_in = 1'b1;
        at_edge(13); set_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            at_edge(20 + i);
            clr_in = (i % 2 == 0);
        end
        at_edge(40); clr_in = 1'b0;
        at_edge(45);

        // 3: set and clr rise together
        do_reset();
`ifdef SR_CONFLICT_EN
        exp_pulse(17, K_C);
        exp_busy(16, 1'b1);
        exp_busy(19, 1'b1);
        exp_busy(20, 1'b0);
`else
        exp_pulse(17, K_S);
        exp_pulse(20, K_R);
        exp_busy(16, 1'b1);
        exp_busy(20, 1'b1);
        exp_busy(22, 1'b1);
        exp_busy(23, 1'b0);
`endif
        at_edge(10); set_in = 1'b1; clr_in = 1'b1;
        at_edge(30); set_in = 1'b0; clr_in = 1'b0;
        at_edge(45);

        // 5: clr pulses arriving while holding off after a set
        do_reset();
        exp_pulse(17, K_S);
        exp_pulse(20, K_R);
        exp_pulse(31, K_R);
        exp_busy(18, 1'b1);
        exp_busy(25, 1'b0);
        exp_busy(30, 1'b1);
        at_edge(10); set_in = 1'b1;
        at_edge(12); clr_in = 1'b1;
        at_edge(18); clr_in = 1'b0;
        at_edge(24); clr_in = 1'b1;
        at_edge(30); clr_in = 1'b0;
        at_edge(40); set_in = 1'b0;
        at_edge(55);

        // 6: reset on the issuing edge drops the request; held input re-fires after release
        do_reset();
        exp_busy(16, 1'b1);
        exp_busy(17, 1'b0);
        exp_busy(18, 1'b0);
        exp_busy(24, 1'b1);
        exp_pulse(25, K_S);
        at_edge(10); set_in = 1'b1;
        at_edge(17); rst = 1'b1;
        at_edge(18); rst = 1'b0;
        at_edge(30); set_in = 1'b0;
        at_edge(45);

        @(posedge ck);
        total++;
        if (evq.size() != 0) begin
            bad++;
            $display("FAIL leftover_pulses: got %0d unmatched, required 0", evq.size());
        end
        total++;
        if (bq.size() != 0) begin
            bad++;
            $display("FAIL leftover_busy: got %0d unchecked, required 0", bq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_pulse_gen.md
Name: sr_pulse_gen

Overview:
- Upstream command stage for the negedge-clocked set/reset flip-flop.
- Takes two raw, asynchronous, possibly bouncing level inputs and produces clean one-cycle s / r pulses.
- Processing per input: synchronise, debounce, rising-edge detect, latch as a pending request.
- An arbiter FSM issues the pulses, never both at once, with a hold-off gap between them.
- Outputs change on posedge ck, so each pulse is stable across exactly one downstream negedge.

Parameters:
- DB_CYCLES, 4: consecutive cycles the synchronised input must differ from its filtered value before the filtered value flips. Range 1..255.
- HOLDOFF, 2: idle cycles forced after every issued pulse. Range 1..255.

Ports:
- ck  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- set_in  in  1  raw set request level, asynchronous.
- clr_in  in  1  raw reset request level, asynchronous.
- s  out  1  registered one-cycle set pulse to the flip-flop.
- r  out  1  registered one-cycle reset pulse to the flip-flop.
- busy  out  1  high when the FSM is not IDLE or a request is pending.
- conflict  out  1  one-cycle flag; only driven when SR_CONFLICT_EN is defined.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While rst is sampled high at posedge ck, all state clears:
  - synchroniser flops, filtered levels, debounce counters, pending bits = 0;
  - FSM = IDLE, hold counter = 0;
  - s = r = busy = conflict = 0.
- Reset mid-operation: a pulse in flight or pending request is dropped. s/r are 0 from the first reset edge onward; nothing is replayed after release.
- Synchroniser: two flops per input.
- Debounce, per channel:
  - counter increments while sync != filtered, and clears when they are equal;
  - filtered flips on the edge where the DB_CYCLES-th consecutive differing sample is taken.
- Edge detect: a 0->1 transition of filtered sets that channel's pending bit on the next edge. Falling edges are ignored.
- Pending is sticky; further rising edges while already pending coalesce into it.
- An input held high through reset release counts as a rising edge after debounce.
- FSM states: IDLE, HOLD.
  - IDLE, set pending: s<=1, clear set pending, load hold counter with HOLDOFF, go to HOLD.
  - IDLE, only clr pending: same, but drives r and clears clr pending.
  - IDLE, both pending: set wins (matches the flip-flop's priority); clr stays pending.
  - HOLD: s=r=0; counter decrements; go to IDLE on the edge where it reaches 0.
  - Pending bits may still set during HOLD.
- Latency: let N be the first posedge sampling set_in=1 (stable, FSM idle). Then s=1 for exactly the cycle after posedge N+DB_CYCLES+3.
- Pulse spacing: if a pulse is issued at edge P, the earliest next pulse is at edge P+1+HOLDOFF.
- Invariants:
  - s & r never both 1;
  - every pulse is exactly one cycle wide;
  - busy is combinational from registered state.

Optional Feature:
SR_CONFLICT_EN
- Defined: in IDLE with both pending bits set, both are cleared and no pulse is issued. conflict=1 for that one cycle, and the FSM enters HOLD for HOLDOFF cycles.
- Undefined: conflict is tied to 0 and set-priority sequencing applies.

Test Plan (DB_CYCLES=4, HOLDOFF=2):
1. Reset then set_in 0->1 sampled at edge 10, held -> s=1 only in the cycle after edge 17; r stays 0; busy high from edge 16 through HOLD, low after edge 20.
2. set_in high for 3 cycles then low; then clr_in toggling every cycle for 20 cycles -> no s or r pulse, busy stays 0.
3. set_in and clr_in rise together at edge 10 (macro undefined) -> s in the cycle after edge 17, r in the cycle after edge 20; conflict=0 throughout.
4. Same stimulus with SR_CONFLICT_EN defined -> no s/r pulse; conflict=1 in the cycle after edge 17; busy drops after edge 20.
5. clr_in pulses high for 6 cycles twice with a 6-cycle gap, during which the FSM is in HOLD from an earlier set -> exactly two r pulses, each one cycle wide, spaced ≥3 cycles.
6. rst asserted on the edge where pending set would issue -> s never rises; after release with set_in still high, s fires DB_CYCLES+4 edges later (set_in remains high and is seen as a new rising edge after debounce).
